issue_scheduler: RTL and testbench

//  Parametrised in-order issue stage with an internal scoreboard.

---
 rtl/issue_scheduler.sv | 112 +++++++++++
 tb/tb_issue_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// In-order issue stage: scoreboard RAW/WAW check, class-matched round-robin
// dispatch with a one-cycle registered strobe, and busy clear from writeback ports.
module issue_scheduler #(
  parameter int unsigned NUM_UNITS = 5,
  parameter int unsigned CLASS_W = 3,
  parameter logic [NUM_UNITS*CLASS_W-1:0] UNIT_CLASS = {3'd4, 3'd3, 3'd2, 3'd1, 3'd1},
  parameter int unsigned RN_W = 7,
  parameter int unsigned WB_PORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CLASS_W-1:0]       in_class,
  input  logic [RN_W-1:0]          in_r1,
  input  logic [RN_W-1:0]          in_r2,
  input  logic [RN_W-1:0]          in_rd,
  input  logic [RN_W-1:0]          in_rd2,
  input  logic [NUM_UNITS-1:0]     unit_busy,
  output logic [NUM_UNITS-1:0]     unit_en,
  output logic [RN_W-1:0]          rd_out,
  output logic [RN_W-1:0]          rd2_out,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*RN_W-1:0] wb_rn,
  input  logic                     flush,
  output logic [2**RN_W-1:0]       reg_busy,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned NumRegs = 2 ** RN_W;
  localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned IdxW = PtrW + 1;

  logic [NumRegs-1:0]   r_busy, w_busy_d;
  logic [NUM_UNITS-1:0] r_unit_en, w_cand, w_sel_oh;
  logic [PtrW-1:0]      r_rr_ptr, w_sel, w_rr_next;
  logic [IdxW-1:0]      w_idx;
  logic [RN_W-1:0]      r_rd_out, r_rd2_out;
  logic [31:0]          r_stall_cnt;
  logic                 w_found, w_hazard, w_accept;

  // A unit strobed last cycle has not yet raised its busy flag, so skip it.
  always_comb begin
    w_cand = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      w_cand[i] = (UNIT_CLASS[i*CLASS_W +: CLASS_W] == in_class) & ~unit_busy[i] & ~r_unit_en[i];
    end
  end

  assign w_hazard = r_busy[in_r1] | r_busy[in_r2]
                  | ((in_rd != '0) & r_busy[in_rd])
                  | ((in_rd2 != '0) & r_busy[in_rd2]);
  assign in_ready = ~flush & ~w_hazard & (|w_cand);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
      w_idx = {1'b0, r_rr_ptr} + IdxW'(j);
      if (w_idx >= IdxW'(NUM_UNITS)) w_idx = w_idx - IdxW'(NUM_UNITS);
      if (!w_found && w_cand[w_idx[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PtrW-1:0];
      end
    end
    w_sel_oh        = '0;
    w_sel_oh[w_sel] = w_found;
    w_rr_next       = (w_sel == PtrW'(NUM_UNITS - 1)) ? '0 : w_sel + 1'b1;
  end

  // Clears applied first so a same-cycle set wins; register 0 is never busy.
  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) w_busy_d[wb_rn[p*RN_W +: RN_W]] = 1'b0;
    end
    if (w_accept) begin
      if (in_rd != '0)  w_busy_d[in_rd]  = 1'b1;
      if (in_rd2 != '0) w_busy_d[in_rd2] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_unit_en   <= '0;
      r_rd_out    <= '0;
      r_rd2_out   <= '0;
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy    <= w_busy_d;
      r_unit_en <= w_accept ? w_sel_oh : '0;
      if (w_accept) begin
        r_rd_out  <= in_rd;
        r_rd2_out <= in_rd2;
        r_rr_ptr  <= w_rr_next;
      end
      if (in_valid && !in_ready && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign unit_en   = r_unit_en;
  assign rd_out    = r_rd_out;
  assign rd2_out   = r_rd2_out;
  assign reg_busy  = r_busy;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: expected dispatches are queued at acceptance
// and a forked monitor pops and compares them whenever a strobe appears.
module tb_issue_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, flush;
  logic [2:0]   in_class;
  logic [6:0]   in_r1, in_r2, in_rd, in_rd2, rd_out, rd2_out;
  logic [4:0]   unit_busy, unit_en;
  logic [1:0]   wb_valid;
  logic [13:0]  wb_rn;
  logic [127:0] reg_busy;
  logic [31:0]  stall_cnt;

  typedef struct {
    logic [4:0] en;
    logic [6:0] rd;
    logic [6:0] rd2;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  issue_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_r1     (in_r1),
    .in_r2     (in_r2),
    .in_rd     (in_rd),
    .in_rd2    (in_rd2),
    .unit_busy (unit_busy),
    .unit_en   (unit_en),
    .rd_out    (rd_out),
    .rd2_out   (rd2_out),
    .wb_valid  (wb_valid),
    .wb_rn     (wb_rn),
    .flush     (flush),
    .reg_busy  (reg_busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [2:0] cls, input logic [6:0] r1, input logic [6:0] r2,
                           input logic [6:0] rd, input logic [6:0] rd2);
    in_class = cls;
    in_r1    = r1;
    in_r2    = r2;
    in_rd    = rd;
    in_rd2   = rd2;
    in_valid = 1'b1;
  endtask

  // Present an instruction, wait (bounded) for acceptance, queue its expected strobe.
  task automatic issue(input string name, input logic [2:0] cls, input logic [6:0] r1,
                       input logic [6:0] r2, input logic [6:0] rd, input logic [6:0] rd2,
                       input logic [4:0] exp_en);
    int waited;
    exp_t e;
    waited = 0;
    set_instr(cls, r1, r2, rd, rd2);
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check({name, "_accept"}, 64'(in_ready), 64'(1));
    if (in_ready) begin
      e.en  = exp_en;
      e.rd  = rd;
      e.rd2 = rd2;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input logic [4:0] exp_en, input logic [6:0] rd, input logic [6:0] rd2);
    exp_t e;
    e.en  = exp_en;
    e.rd  = rd;
    e.rd2 = rd2;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    in_class  = '0;
    in_r1     = '0;
    in_r2     = '0;
    in_rd     = '0;
    in_rd2    = '0;
    unit_busy = '0;
    wb_valid  = '0;
    wb_rn     = '0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && unit_en != 5'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_dispatch", 64'(unit_en), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("dispatch_unit_en", 64'(unit_en), 64'(e.en));
            check("dispatch_rd_out", 64'(rd_out), 64'(e.rd));
            check("dispatch_rd2_out", 64'(rd2_out), 64'(e.rd2));
            check("dispatch_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // T1: build up state (a stall, a busy register, a pending strobe), then reset.
    set_instr(3'd4, 7'd0, 7'd0, 7'd0, 7'd0);
    unit_busy = 5'b10000;
    @(negedge clk);
    check("t1_pre_stall_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    unit_busy = '0;
    set_instr(3'd1, 7'd0, 7'd0, 7'd3, 7'd0);
    @(negedge clk);
    check("t1_pre_accept_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_strobe_dropped", 64'(unit_en), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_reg_busy_clear", 64'(reg_busy == '0), 64'(1));
    check("t1_stall_cnt", 64'(stall_cnt), 64'(0));
    check("t1_rd_out", 64'(rd_out), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // T2: back-to-back class-1 instructions alternate between units 0 and 1.
    issue("t2_rd5", 3'd1, 7'd0, 7'd0, 7'd5, 7'd0, 5'b00001);
    issue("t2_rd6", 3'd1, 7'd0, 7'd0, 7'd6, 7'd0, 5'b00010);
    issue("t2_rd7", 3'd1, 7'd0, 7'd0, 7'd7, 7'd0, 5'b00001);
    @(negedge clk);
    check("t2_busy_5_7", 64'(reg_busy[7:5]), 64'(3'b111));
    @(posedge clk);
    #1;

    // T3: RAW on r9; wb pulse in the 4th stall cycle, accept the cycle after.
    issue("t3_rd9", 3'd1, 7'd0, 7'd0, 7'd9, 7'd0, 5'b00010);
    set_instr(3'd1, 7'd9, 7'd0, 7'd10, 7'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        wb_valid = 2'b01;
        wb_rn    = {7'd0, 7'd9};
      end
      @(negedge clk);
      check("t3_raw_stall_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    wb_valid = '0;
    @(negedge clk);
    check("t3_ready_after_wb", 64'(in_ready), 64'(1));
    if (in_ready) expect_now(5'b00001, 7'd10, 7'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t3_stall_cnt", 64'(stall_cnt), 64'(4));
    check("t3_busy_9", 64'(reg_busy[9]), 64'(0));
    @(posedge clk);
    #1;

    // T4: set of r12 collides with its clear on port 0; port 1 clears r10.
    wb_valid = 2'b11;
    wb_rn    = {7'd10, 7'd12};
    issue("t4_rd12", 3'd1, 7'd0, 7'd0, 7'd12, 7'd0, 5'b00010);
    wb_valid = '0;
    @(negedge clk);
    check("t4_busy_12_set_wins", 64'(reg_busy[12]), 64'(1));
    check("t4_busy_10_cleared", 64'(reg_busy[10]), 64'(0));
    @(posedge clk);
    #1;

    // T5: class-4 blocked by unit_busy for 4 cycles, then one flush cycle.
    set_instr(3'd4, 7'd0, 7'd0, 7'd15, 7'd0);
    unit_busy = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        unit_busy = '0;
        flush     = 1'b1;
      end
      @(negedge clk);
      check("t5_blocked_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    @(negedge clk);
    check("t5_ready_unit4", 64'(in_ready), 64'(1));
    if (in_ready) expect_now(5'b10000, 7'd15, 7'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t5_stall_cnt", 64'(stall_cnt), 64'(9));
    @(posedge clk);
    #1;

    // T6: rd=0 / rd2=20; flush during the strobe cycle must not suppress it.
    issue("t6_dual", 3'd1, 7'd0, 7'd0, 7'd0, 7'd20, 5'b00001);
    flush = 1'b1;
    @(negedge clk);
    check("t6_flush_ready", 64'(in_ready), 64'(0));
    check("t6_busy_20", 64'(reg_busy[20]), 64'(1));
    check("t6_busy_0", 64'(reg_busy[0]), 64'(0));
    @(posedge clk);
    #1 flush = 1'b0;

    // WAW on the second destination blocks a class-2 instruction.
    set_instr(3'd2, 7'd0, 7'd0, 7'd0, 7'd20);
    @(negedge clk);
    check("waw_rd2_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 in_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
